id_stage_hazard: RTL and testbench
==================================

# id_stage_hazard

Parametrised instruction-decode stage for the 5-stage pipeline: decodes the 16-bit instruction fields, reads an 8-entry register file with write-first bypass, resolves operands with MEM/WB forwarding, detects load-use hazards and holds the ID/EX pipeline register behind a valid/ready handshake. It sits between the IF/ID register and the EX stage and consumes control bits from the external controller.

## Interface
- DATA_W, 16: datapath width; DATA_W ≥ 8.
- CTL_W, 8: width of the opaque controller bundle passed through to EX.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  instruction present on if_instr.
- if_ready  out  1  ID accepts instruction this cycle.
- if_instr  in  16  rd=[11:9], rs1=[8:6], rs2=[5:3], imm6=[5:0].
- dec_ctl  in  CTL_W  controller outputs, registered unchanged.
- dec_use_rs1, dec_use_rs2  in  1 each  operand is read.
- dec_rs2_from_rd  in  1  second read address is [11:9] (store data) instead of [5:3].
- dec_imm_sel  in  1  src2 = sign-extended imm6.
- dec_rd_wen, dec_is_load  in  1 each  writes rd / is a load.
- flush  in  1  taken branch/jump: kill ID and ID/EX contents.
- mem_wen  in  1, mem_rd  in  3, mem_data  in  DATA_W  MEM-stage forward source.
- wb_wen  in  1, wb_rd  in  3, wb_data  in  DATA_W  register-file write port.
- ex_ready  in  1  EX accepts ID/EX contents.
- ex_valid  out  1; ex_src1, ex_src2, ex_store_data  out  DATA_W; ex_rd  out  3; ex_rd_wen, ex_is_load  out  1; ex_ctl  out  CTL_W; ex_rs1, ex_rs2  out  3 (read addresses, for EX-side forwarding).

## Operation
- Register file: 8 × DATA_W; R0 reads zero, writes to R0 ignored. Write on wb_wen. Same-cycle read of wb_rd returns wb_data (write-first).
- rd2_addr = dec_rs2_from_rd ? [11:9] : [5:3]. Raw2 = operand value for rd2_addr.
- Operand resolve per source (addr ≠ 0 only): mem_wen & mem_rd match → mem_data; else wb_wen & wb_rd match → wb_data; else register file. MEM has priority over WB.
- ex_src2 = dec_imm_sel ? sext(imm6, DATA_W) : raw2; ex_store_data = raw2 (resolved).
- Load-use hazard: ex_valid & ex_is_load & ex_rd_wen & ex_rd ≠ 0 & ((dec_use_rs1 & ex_rd == rs1) | (dec_use_rs2 & ex_rd == rd2_addr)).
- advance = ~ex_valid | ex_ready.
- if_ready = flush | (advance & ~hazard).
- Edge priority: rst > flush > advance. flush: ex_valid ← 0, instruction in ID dropped. advance & if_valid & ~hazard: capture all ex_* fields, ex_valid ← 1. advance & (hazard | ~if_valid): bubble, ex_valid ← 0, other fields don't-care. ~advance: ID/EX held unchanged.
- Bubbles carry ex_rd_wen = 0 and ex_is_load = 0.

## Timing
- Reset: ex_valid, all ex_* fields, all registers = 0; if_ready = 0 during rst, follows equations after.
- Latency: 1 cycle if_instr → ex_*; if_ready and hazard purely combinational from current inputs and ID/EX state.
- Load-use stall: exactly 1 bubble cycle; next cycle load is in MEM and the operand arrives via mem_data only after the MEM stage supplies it (mem_data must be load data when mem_wen asserts for a load).
- ex_ready low with ex_valid high: ID/EX frozen, if_ready = 0 (unless flush).
- flush concurrent with hazard or ex_ready low: flush wins; ID/EX cleared next edge.
- WB write and ID capture of same register in one cycle: captured value is wb_data.

## Configuration
- ID_FWD_EN defined: MEM/WB forwarding as above; only load-use stalls.
- Not defined: no MEM forwarding; hazard extends to any RAW against valid ID/EX writer (ex_rd_wen) or mem_wen/mem_rd match; stall holds until the producer reaches WB, where write-first bypass supplies the value. mem_data ignored.

## Test plan
- Reset then wb write R3=0x1234; next cycle instr rs1=3 → ex_src1=0x1234, ex_valid=1 one edge later.
- Load R2 in ID/EX, next instr uses rs1=2 → if_ready=0 one cycle, bubble (ex_valid=0), then captured with ex_src1=mem_data=0xBEEF.
- mem_rd=4 data 0x0011 and wb_rd=4 data 0x0022 same cycle, rs2=4 → ex_src2=0x0011 (MEM priority); without ID_FWD_EN → stall until WB.
- Write R0=0xFFFF, read rs1=0 → ex_src1=0; imm6=0x3F with dec_imm_sel → ex_src2 = all ones (DATA_W=16: 0xFFFF).
- ex_ready=0 for 3 cycles with valid ID/EX → ex_* unchanged, if_ready=0; flush asserted during hold → ex_valid=0 next edge, if_ready=1.
- rst asserted mid-stall → all outputs 0 next edge, register file cleared.

Source files
------------

// File: rtl/id_stage_hazard_if.sv
// id_stage_hazard_if
// ---------------------------------------------------------------------------
// ID/EX pipeline bus between the decode stage and the EX stage.
//
// Parameters:
//   DATA_W - datapath width
//   CTL_W  - width of the opaque controller bundle carried to EX
//
// Signals:
//   ex_valid       ID/EX register holds a live instruction
//   ex_ready       EX accepts the ID/EX contents this cycle
//   ex_src1/src2   resolved operands (src2 may be the sign-extended immediate)
//   ex_store_data  resolved second-read value (store data)
//   ex_rd          destination register
//   ex_rd_wen      instruction writes ex_rd
//   ex_is_load     instruction is a load
//   ex_ctl         controller bundle, passed through untouched
//   ex_rs1/ex_rs2  read addresses, for forwarding on the EX side
//
// Modports:
//   master - the ID stage (drives the bus, observes ex_ready)
//   slave  - the EX stage (consumes the bus, drives ex_ready)
// ---------------------------------------------------------------------------
interface id_stage_hazard_if #(
   parameter int DATA_W = 16,
   parameter int CTL_W  = 8
);
   logic              ex_valid;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_src1;
   logic [DATA_W-1:0] ex_src2;
   logic [DATA_W-1:0] ex_store_data;
   logic [2:0]        ex_rd;
   logic              ex_rd_wen;
   logic              ex_is_load;
   logic [CTL_W-1:0]  ex_ctl;
   logic [2:0]        ex_rs1;
   logic [2:0]        ex_rs2;

   modport master (
      output ex_valid, ex_src1, ex_src2, ex_store_data, ex_rd, ex_rd_wen,
             ex_is_load, ex_ctl, ex_rs1, ex_rs2,
      input  ex_ready
   );

   modport slave (
      input  ex_valid, ex_src1, ex_src2, ex_store_data, ex_rd, ex_rd_wen,
             ex_is_load, ex_ctl, ex_rs1, ex_rs2,
      output ex_ready
   );
endinterface

// File: rtl/id_stage_hazard.sv
// id_stage_hazard
// ---------------------------------------------------------------------------
// Instruction-decode stage of the 5-stage pipeline. Splits the 16-bit
// instruction into fields, reads an 8-entry register file (write-first),
// resolves operands, detects data hazards and holds the ID/EX register
// behind a valid/ready handshake toward EX.
//
// Optional feature macro: ID_FWD_EN
//   defined   - MEM/WB operand forwarding; only load-use hazards stall.
//   undefined - no MEM forwarding (mem_data unused); any RAW against the
//               ID/EX writer or the MEM-stage writer stalls until the value
//               reaches WB, where the write-first bypass supplies it.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_if_valid/o_if_ready/i_if_instr   handshake with the IF/ID register
//   i_dec_*              controller decode bits for the instruction in ID
//   i_flush              taken branch/jump: kill ID and ID/EX
//   i_mem_wen/rd/data    MEM-stage forward source
//   i_wb_wen/rd/data     register-file write port (WB stage)
//   exBus                ID/EX bus (master side)
// ---------------------------------------------------------------------------
module id_stage_hazard #(
   parameter int DATA_W = 16,
   parameter int CTL_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_if_valid,
   output logic               o_if_ready,
   input  logic [15:0]        i_if_instr,
   input  logic [CTL_W-1:0]   i_dec_ctl,
   input  logic               i_dec_use_rs1,
   input  logic               i_dec_use_rs2,
   input  logic               i_dec_rs2_from_rd,
   input  logic               i_dec_imm_sel,
   input  logic               i_dec_rd_wen,
   input  logic               i_dec_is_load,
   input  logic               i_flush,
   input  logic               i_mem_wen,
   input  logic [2:0]         i_mem_rd,
   input  logic [DATA_W-1:0]  i_mem_data,
   input  logic               i_wb_wen,
   input  logic [2:0]         i_wb_rd,
   input  logic [DATA_W-1:0]  i_wb_data,
   id_stage_hazard_if.master  exBus
);

   logic [DATA_W-1:0] r_regFile [0:7];

   logic              r_exValid;
   logic [DATA_W-1:0] r_exSrc1;
   logic [DATA_W-1:0] r_exSrc2;
   logic [DATA_W-1:0] r_exStoreData;
   logic [2:0]        r_exRd;
   logic              r_exRdWen;
   logic              r_exIsLoad;
   logic [CTL_W-1:0]  r_exCtl;
   logic [2:0]        r_exRs1;
   logic [2:0]        r_exRs2;

   logic [2:0]        w_rd;
   logic [2:0]        w_rs1;
   logic [2:0]        w_rd2Addr;
   logic [DATA_W-1:0] w_immExt;
   logic [DATA_W-1:0] w_raw1;
   logic [DATA_W-1:0] w_raw2;
   logic              w_exMatch;
   logic              w_hazard;
   logic              w_advance;
   logic              w_capture;
   logic              w_unused;

   // Field extraction. The second read port serves either rs2 or, for
   // stores, the rd field that names the data register.
   assign w_rd      = i_if_instr[11:9];
   assign w_rs1     = i_if_instr[8:6];
   assign w_rd2Addr = i_dec_rs2_from_rd ? i_if_instr[11:9] : i_if_instr[5:3];
   assign w_immExt  = {{(DATA_W-6){i_if_instr[5]}}, i_if_instr[5:0]};

   // Does the ID/EX producer write a register this instruction reads?
   assign w_exMatch = (r_exRd != 3'd0) &&
                      ((i_dec_use_rs1 && (r_exRd == w_rs1)) ||
                       (i_dec_use_rs2 && (r_exRd == w_rd2Addr)));

`ifdef ID_FWD_EN
   // With forwarding, MEM beats WB beats the register file. R0 is never
   // forwarded so it always reads as zero.
   always_comb begin
      w_raw1 = r_regFile[w_rs1];
      if (w_rs1 != 3'd0) begin
         if (i_mem_wen && (i_mem_rd == w_rs1))
            w_raw1 = i_mem_data;
         else if (i_wb_wen && (i_wb_rd == w_rs1))
            w_raw1 = i_wb_data;
      end
      w_raw2 = r_regFile[w_rd2Addr];
      if (w_rd2Addr != 3'd0) begin
         if (i_mem_wen && (i_mem_rd == w_rd2Addr))
            w_raw2 = i_mem_data;
         else if (i_wb_wen && (i_wb_rd == w_rd2Addr))
            w_raw2 = i_wb_data;
      end
   end

   // Only a load sitting in ID/EX cannot be forwarded in time: its data
   // appears on the MEM forward path one cycle later.
   assign w_hazard = r_exValid && r_exIsLoad && r_exRdWen && w_exMatch;

   assign w_unused = ^i_if_instr[15:12];
`else
   logic w_memMatch;

   // Without forwarding the only bypass is the register file's write-first
   // path from the WB port.
   always_comb begin
      w_raw1 = r_regFile[w_rs1];
      if ((w_rs1 != 3'd0) && i_wb_wen && (i_wb_rd == w_rs1))
         w_raw1 = i_wb_data;
      w_raw2 = r_regFile[w_rd2Addr];
      if ((w_rd2Addr != 3'd0) && i_wb_wen && (i_wb_rd == w_rd2Addr))
         w_raw2 = i_wb_data;
   end

   assign w_memMatch = i_mem_wen && (i_mem_rd != 3'd0) &&
                       ((i_dec_use_rs1 && (i_mem_rd == w_rs1)) ||
                        (i_dec_use_rs2 && (i_mem_rd == w_rd2Addr)));

   // Any producer still in EX or MEM blocks the consumer until it is in WB.
   assign w_hazard = (r_exValid && r_exRdWen && w_exMatch) || w_memMatch;

   assign w_unused = ^{i_if_instr[15:12], i_mem_data};
`endif

   // Handshake: ID/EX can move whenever it is empty or EX takes it. A flush
   // always frees ID; nothing is accepted while reset is held.
   assign w_advance  = !r_exValid || exBus.ex_ready;
   assign w_capture  = w_advance && i_if_valid && !w_hazard;
   assign o_if_ready = !rst && (i_flush || (w_advance && !w_hazard));

   // Register file: cleared on reset, written from WB. R0 is never written
   // so it keeps its reset value of zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++)
            r_regFile[i] <= '0;
      end else if (i_wb_wen && (i_wb_rd != 3'd0)) begin
         r_regFile[i_wb_rd] <= i_wb_data;
      end
   end

   // ID/EX register: reset beats flush beats advance. Flushes and bubbles
   // also drop the write/load flags so a dead slot can never look like a
   // producer to the hazard logic. When EX stalls, everything holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exValid     <= 1'b0;
         r_exSrc1      <= '0;
         r_exSrc2      <= '0;
         r_exStoreData <= '0;
         r_exRd        <= '0;
         r_exRdWen     <= 1'b0;
         r_exIsLoad    <= 1'b0;
         r_exCtl       <= '0;
         r_exRs1       <= '0;
         r_exRs2       <= '0;
      end else if (i_flush) begin
         r_exValid  <= 1'b0;
         r_exRdWen  <= 1'b0;
         r_exIsLoad <= 1'b0;
      end else if (w_capture) begin
         r_exValid     <= 1'b1;
         r_exSrc1      <= w_raw1;
         r_exSrc2      <= i_dec_imm_sel ? w_immExt : w_raw2;
         r_exStoreData <= w_raw2;
         r_exRd        <= w_rd;
         r_exRdWen     <= i_dec_rd_wen;
         r_exIsLoad    <= i_dec_is_load;
         r_exCtl       <= i_dec_ctl;
         r_exRs1       <= w_rs1;
         r_exRs2       <= w_rd2Addr;
      end else if (w_advance) begin
         r_exValid  <= 1'b0;
         r_exRdWen  <= 1'b0;
         r_exIsLoad <= 1'b0;
      end
   end

   assign exBus.ex_valid      = r_exValid;
   assign exBus.ex_src1       = r_exSrc1;
   assign exBus.ex_src2       = r_exSrc2;
   assign exBus.ex_store_data = r_exStoreData;
   assign exBus.ex_rd         = r_exRd;
   assign exBus.ex_rd_wen     = r_exRdWen;
   assign exBus.ex_is_load    = r_exIsLoad;
   assign exBus.ex_ctl        = r_exCtl;
   assign exBus.ex_rs1        = r_exRs1;
   assign exBus.ex_rs2        = r_exRs2;

endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard
// ---------------------------------------------------------------------------
// Directed bench for id_stage_hazard (DATA_W=16, CTL_W=8). Inputs change 1ns
// after each rising edge; combinational outputs are sampled 1ns later and
// registered outputs 1ns after the edge that loads them. Where behaviour
// depends on ID_FWD_EN the expected sequence branches on the same macro.
// ---------------------------------------------------------------------------
module tb_id_stage_hazard;

   localparam int DATA_W = 16;
   localparam int CTL_W  = 8;

   logic              clk;
   logic              rst;
   logic              ifValid;
   logic              ifReady;
   logic [15:0]       ifInstr;
   logic [CTL_W-1:0]  decCtl;
   logic              useRs1;
   logic              useRs2;
   logic              rs2FromRd;
   logic              immSel;
   logic              rdWen;
   logic              isLoad;
   logic              flush;
   logic              memWen;
   logic [2:0]        memRd;
   logic [DATA_W-1:0] memData;
   logic              wbWen;
   logic [2:0]        wbRd;
   logic [DATA_W-1:0] wbData;

   int passCount;
   int totalCount;

   id_stage_hazard_if #(.DATA_W(DATA_W), .CTL_W(CTL_W)) exBus ();

   id_stage_hazard #(.DATA_W(DATA_W), .CTL_W(CTL_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_if_valid        (ifValid),
      .o_if_ready        (ifReady),
      .i_if_instr        (ifInstr),
      .i_dec_ctl         (decCtl),
      .i_dec_use_rs1     (useRs1),
      .i_dec_use_rs2     (useRs2),
      .i_dec_rs2_from_rd (rs2FromRd),
      .i_dec_imm_sel     (immSel),
      .i_dec_rd_wen      (rdWen),
      .i_dec_is_load     (isLoad),
      .i_flush           (flush),
      .i_mem_wen         (memWen),
      .i_mem_rd          (memRd),
      .i_mem_data        (memData),
      .i_wb_wen          (wbWen),
      .i_wb_rd           (wbRd),
      .i_wb_data         (wbData),
      .exBus             (exBus)
   );

   // 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and its decode bits to ID
   task automatic applyStimulus(input logic v, input logic [15:0] instr,
                                input logic u1, input logic u2,
                                input logic fromRd, input logic imm,
                                input logic wen, input logic ld);
      ifValid   = v;
      ifInstr   = instr;
      useRs1    = u1;
      useRs2    = u2;
      rs2FromRd = fromRd;
      immSel    = imm;
      rdWen     = wen;
      isLoad    = ld;
   endtask

   // One comparison against a hand-computed value
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      passCount  = 0;
      totalCount = 0;
      rst        = 1'b1;
      decCtl     = '0;
      flush      = 1'b0;
      memWen     = 1'b0;
      memRd      = '0;
      memData    = '0;
      wbWen      = 1'b0;
      wbRd       = '0;
      wbData     = '0;
      exBus.ex_ready = 1'b1;
      applyStimulus(1'b0, 16'h0000, 0, 0, 0, 0, 0, 0);

      // Reset state
      stepClock();
      stepClock();
      checkOutput("rst_if_ready", ifReady, 0);
      checkOutput("rst_ex_valid", exBus.ex_valid, 0);
      checkOutput("rst_ex_src1", exBus.ex_src1, 0);
      checkOutput("rst_ex_rd", exBus.ex_rd, 0);

      // Write R3 = 0x1234 with nothing in ID
      rst = 1'b0;
      wbWen = 1'b1; wbRd = 3'd3; wbData = 16'h1234;
      #1;
      checkOutput("idle_if_ready", ifReady, 1);
      stepClock();
      checkOutput("idle_ex_valid", exBus.ex_valid, 0);

      // rd=1, rs1=3: reads R3 from the register file
      wbWen = 1'b0;
      decCtl = 8'hA5;
      applyStimulus(1'b1, 16'h02C0, 1, 0, 0, 0, 1, 0);
      stepClock();
      checkOutput("rf_ex_valid", exBus.ex_valid, 1);
      checkOutput("rf_ex_src1", exBus.ex_src1, 16'h1234);
      checkOutput("rf_ex_rd", exBus.ex_rd, 1);
      checkOutput("rf_ex_ctl", exBus.ex_ctl, 8'hA5);
      checkOutput("rf_ex_rs1", exBus.ex_rs1, 3);

      // Load into R2 (reads nothing)
      decCtl = 8'h3C;
      applyStimulus(1'b1, 16'h0400, 0, 0, 0, 0, 1, 1);
      stepClock();
      checkOutput("ld_ex_is_load", exBus.ex_is_load, 1);
      checkOutput("ld_ex_rd", exBus.ex_rd, 2);

      // rd=5, rs1=2 right behind the load: load-use stall
      applyStimulus(1'b1, 16'h0A80, 1, 0, 0, 0, 1, 0);
      #1;
      checkOutput("lu_if_ready", ifReady, 0);
      stepClock();
      checkOutput("lu_bubble_valid", exBus.ex_valid, 0);
      checkOutput("lu_bubble_rd_wen", exBus.ex_rd_wen, 0);

      // Load now in MEM carrying 0xBEEF
      memWen = 1'b1; memRd = 3'd2; memData = 16'hBEEF;
`ifdef ID_FWD_EN
      #1;
      checkOutput("lu_mem_if_ready", ifReady, 1);
      stepClock();
      checkOutput("lu_fwd_valid", exBus.ex_valid, 1);
      checkOutput("lu_fwd_src1", exBus.ex_src1, 16'hBEEF);
      checkOutput("lu_fwd_rd", exBus.ex_rd, 5);
      memWen = 1'b0;
      wbWen = 1'b1; wbRd = 3'd2; wbData = 16'hBEEF;
      applyStimulus(1'b0, 16'h0000, 0, 0, 0, 0, 0, 0);
      stepClock();
`else
      #1;
      checkOutput("lu_mem_if_ready", ifReady, 0);
      stepClock();
      checkOutput("lu_mem_bubble", exBus.ex_valid, 0);
      memWen = 1'b0;
      wbWen = 1'b1; wbRd = 3'd2; wbData = 16'hBEEF;
      #1;
      checkOutput("lu_wb_if_ready", ifReady, 1);
      stepClock();
      checkOutput("lu_wb_valid", exBus.ex_valid, 1);
      checkOutput("lu_wb_src1", exBus.ex_src1, 16'hBEEF);
      checkOutput("lu_wb_rd", exBus.ex_rd, 5);
      applyStimulus(1'b0, 16'h0000, 0, 0, 0, 0, 0, 0);
      stepClock();
`endif
      wbWen = 1'b0;
      checkOutput("drain_valid", exBus.ex_valid, 0);

      // MEM and WB both target R4; rd=6, rs2=4
      memWen = 1'b1; memRd = 3'd4; memData = 16'h0011;
      wbWen  = 1'b1; wbRd  = 3'd4; wbData  = 16'h0022;
      applyStimulus(1'b1, 16'h0C20, 0, 1, 0, 0, 1, 0);
`ifdef ID_FWD_EN
      #1;
      checkOutput("pri_if_ready", ifReady, 1);
      stepClock();
`else
      #1;
      checkOutput("pri_if_ready", ifReady, 0);
      stepClock();
      checkOutput("pri_bubble", exBus.ex_valid, 0);
      memWen = 1'b0;
      wbWen = 1'b1; wbRd = 3'd4; wbData = 16'h0011;
      stepClock();
`endif
      checkOutput("pri_valid", exBus.ex_valid, 1);
      checkOutput("pri_src2", exBus.ex_src2, 16'h0011);
      checkOutput("pri_store_data", exBus.ex_store_data, 16'h0011);
      checkOutput("pri_rs2", exBus.ex_rs2, 4);
      memWen = 1'b0; wbWen = 1'b0;
      applyStimulus(1'b0, 16'h0000, 0, 0, 0, 0, 0, 0);
      stepClock();

      // Write to R0 is ignored; rd=7, rs1=0, imm6=0x3F
      wbWen = 1'b1; wbRd = 3'd0; wbData = 16'hFFFF;
      decCtl = 8'h5A;
      applyStimulus(1'b1, 16'h0E3F, 1, 0, 0, 1, 1, 0);
      stepClock();
      wbWen = 1'b0;
      checkOutput("r0_src1", exBus.ex_src1, 0);
      checkOutput("imm_src2", exBus.ex_src2, 16'hFFFF);
      checkOutput("imm_store_data", exBus.ex_store_data, 0);
      checkOutput("imm_rd", exBus.ex_rd, 7);

      // EX stalls for three cycles: ID/EX frozen
      exBus.ex_ready = 1'b0;
      decCtl = 8'h00;
      applyStimulus(1'b1, 16'h0200, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("hold_if_ready", ifReady, 0);
         stepClock();
         checkOutput("hold_valid", exBus.ex_valid, 1);
         checkOutput("hold_src2", exBus.ex_src2, 16'hFFFF);
         checkOutput("hold_ctl", exBus.ex_ctl, 8'h5A);
      end

      // Flush during the stall wins
      flush = 1'b1;
      #1;
      checkOutput("flush_if_ready", ifReady, 1);
      stepClock();
      checkOutput("flush_valid", exBus.ex_valid, 0);
      flush = 1'b0;
      exBus.ex_ready = 1'b1;

      // Load R2 again, then stall on it and reset in the middle
      applyStimulus(1'b1, 16'h0400, 0, 0, 0, 0, 1, 1);
      stepClock();
      applyStimulus(1'b1, 16'h0A80, 1, 0, 0, 0, 1, 0);
      #1;
      checkOutput("rst_stall_if_ready", ifReady, 0);
      rst = 1'b1;
      stepClock();
      checkOutput("rst2_valid", exBus.ex_valid, 0);
      checkOutput("rst2_is_load", exBus.ex_is_load, 0);
      checkOutput("rst2_rd", exBus.ex_rd, 0);
      checkOutput("rst2_if_ready", ifReady, 0);

      // Register file cleared: R3 now reads zero
      rst = 1'b0;
      applyStimulus(1'b1, 16'h02C0, 1, 0, 0, 0, 1, 0);
      stepClock();
      checkOutput("rst2_rf_valid", exBus.ex_valid, 1);
      checkOutput("rst2_rf_src1", exBus.ex_src1, 0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
